// File: rtl/decodificador_comando_if.sv
// Byte-pair request bus: UART receiver side in, decoded request and error status out.
interface decodificador_comando_if;
    logic       bytesRecebidos;
    logic [7:0] primeiroByte;
    logic [7:0] segundoByte;
    logic       pedidoAceito;
    logic       pedidoValido;
    logic [7:0] comando;
    logic [7:0] endereco;
    logic       erro;
    logic [1:0] codigoErro;
    logic       descartado;

    modport master (
        output bytesRecebidos,
        output primeiroByte,
        output segundoByte,
        output pedidoAceito,
        input  pedidoValido,
        input  comando,
        input  endereco,
        input  erro,
        input  codigoErro,
        input  descartado
    );

    modport slave (
        input  bytesRecebidos,
        input  primeiroByte,
        input  segundoByte,
        input  pedidoAceito,
        output pedidoValido,
        output comando,
        output endereco,
        output erro,
        output codigoErro,
        output descartado
    );
endinterface

// File: rtl/decodificador_comando.sv
// Turns a (command, sensor address) byte pair from the UART into a held request,
// reporting invalid fields, inter-byte timeouts and dropped bytes.
module decodificador_comando #(
    parameter int unsigned CICLOS_TIMEOUT = 104180
) (
    input logic                    clock,
    input logic                    reset_n,
    decodificador_comando_if.slave bus
);
    typedef enum logic [2:0] {
        StEspera,
        StAguardaSegundo,
        StValida,
        StPendente,
        StErro
    } estado_t;

    localparam logic [17:0] UltimoCiclo = 18'(CICLOS_TIMEOUT - 1);

    estado_t     estado_q, estado_d;
    logic        paridade_q, paridade_d;
    logic [17:0] contador_q, contador_d;
    logic [7:0]  cmd_cap_q, cmd_cap_d;
    logic [7:0]  end_cap_q, end_cap_d;
    logic [1:0]  codigo_pend_q, codigo_pend_d;
    logic        pedido_valido_q, pedido_valido_d;
    logic [7:0]  comando_q, comando_d;
    logic [7:0]  endereco_q, endereco_d;
    logic [1:0]  codigo_erro_q, codigo_erro_d;
    logic        erro_q, erro_d;
    logic        descartado_q, descartado_d;
    logic        aceite;

    // An acknowledge only counts once the request is actually visible downstream.
    assign aceite = bus.pedidoAceito & pedido_valido_q;

    always_comb begin
        estado_d        = estado_q;
        paridade_d      = paridade_q ^ bus.bytesRecebidos;
        contador_d      = contador_q;
        cmd_cap_d       = cmd_cap_q;
        end_cap_d       = end_cap_q;
        codigo_pend_d   = codigo_pend_q;
        pedido_valido_d = pedido_valido_q;
        comando_d       = comando_q;
        endereco_d      = endereco_q;
        codigo_erro_d   = codigo_erro_q;
        erro_d          = 1'b0;
        descartado_d    = 1'b0;

        case (estado_q)
            StEspera: begin
                if (bus.bytesRecebidos) begin
                    if (!paridade_q) begin
                        estado_d   = StAguardaSegundo;
                        contador_d = '0;
                    end else begin
                        descartado_d = 1'b1;
                    end
                end
            end
            StAguardaSegundo: begin
                // A byte arriving on the timeout cycle still completes the pair.
                if (bus.bytesRecebidos) begin
                    cmd_cap_d = bus.primeiroByte;
                    end_cap_d = bus.segundoByte;
                    estado_d  = StValida;
                end else if (contador_q == UltimoCiclo) begin
                    codigo_pend_d = 2'b11;
                    estado_d      = StErro;
                end else begin
                    contador_d = contador_q + 18'd1;
                end
            end
            StValida: begin
                if (cmd_cap_q > 8'h06) begin
                    codigo_pend_d = 2'b01;
                    estado_d      = StErro;
                end else if (end_cap_q > 8'h1F) begin
                    codigo_pend_d = 2'b10;
                    estado_d      = StErro;
                end else begin
                    estado_d = StPendente;
                end
            end
            StPendente: begin
                if (!pedido_valido_q) begin
                    pedido_valido_d = 1'b1;
                    comando_d       = cmd_cap_q;
                    endereco_d      = end_cap_q;
                end else if (aceite) begin
                    pedido_valido_d = 1'b0;
                    estado_d        = StEspera;
                end
                if (bus.bytesRecebidos && paridade_q) begin
                    descartado_d = 1'b1;
                end
            end
            StErro: begin
                erro_d        = 1'b1;
                codigo_erro_d = codigo_pend_q;
                estado_d      = StEspera;
            end
            default: estado_d = StEspera;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q        <= StEspera;
            paridade_q      <= 1'b0;
            contador_q      <= '0;
            cmd_cap_q       <= '0;
            end_cap_q       <= '0;
            codigo_pend_q   <= '0;
            pedido_valido_q <= 1'b0;
            comando_q       <= '0;
            endereco_q      <= '0;
            codigo_erro_q   <= '0;
            erro_q          <= 1'b0;
            descartado_q    <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            paridade_q      <= paridade_d;
            contador_q      <= contador_d;
            cmd_cap_q       <= cmd_cap_d;
            end_cap_q       <= end_cap_d;
            codigo_pend_q   <= codigo_pend_d;
            pedido_valido_q <= pedido_valido_d;
            comando_q       <= comando_d;
            endereco_q      <= endereco_d;
            codigo_erro_q   <= codigo_erro_d;
            erro_q          <= erro_d;
            descartado_q    <= descartado_d;
        end
    end

    assign bus.pedidoValido = pedido_valido_q;
    assign bus.comando      = comando_q;
    assign bus.endereco     = endereco_q;
    assign bus.erro         = erro_q;
    assign bus.codigoErro   = codigo_erro_q;
    assign bus.descartado   = descartado_q;
endmodule

// File: tb/tb_decodificador_comando.sv
// Randomised bench for decodificador_comando against a pair-level reference model.
module tb_decodificador_comando;
    localparam int unsigned Timeout = 100;

    logic       clock;
    logic       reset_n;
    int         n_tests;
    int         n_fail;
    int         erro_seen;
    int         desc_seen;
    logic [1:0] last_code;

    decodificador_comando_if bus ();

    decodificador_comando #(
        .CICLOS_TIMEOUT(Timeout)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled just after each rising edge.
    initial begin
        erro_seen = 0;
        desc_seen = 0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.erro) erro_seen++;
            if (bus.descartado) desc_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference rule: command must be 0..6, address 0..31, command error wins.
    function automatic logic [1:0] code_for(input logic [7:0] cmd, input logic [7:0] addr);
        if (cmd > 8'h06) return 2'b01;
        if (addr > 8'h1F) return 2'b10;
        return 2'b00;
    endfunction

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic send_byte(input bit second, input logic [7:0] b);
        if (second) bus.segundoByte = b;
        else bus.primeiroByte = b;
        bus.bytesRecebidos = 1'b1;
        @(negedge clock);
        bus.bytesRecebidos = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_pv"}, 32'(bus.pedidoValido), 32'd0);
        check_val({tag, "_cmd"}, 32'(bus.comando), 32'd0);
        check_val({tag, "_addr"}, 32'(bus.endereco), 32'd0);
        check_val({tag, "_erro"}, 32'(bus.erro), 32'd0);
        check_val({tag, "_code"}, 32'(bus.codigoErro), 32'd0);
        check_val({tag, "_desc"}, 32'(bus.descartado), 32'd0);
    endtask

    task automatic run_pair(input logic [7:0] cmd, input logic [7:0] addr, input int gap,
                            output logic [1:0] code);
        int e0;
        e0   = erro_seen;
        code = code_for(cmd, addr);
        send_byte(1'b0, cmd);
        repeat (gap) @(negedge clock);
        send_byte(1'b1, addr);
        @(negedge clock);
        check_val("pv_not_before_n2", 32'(bus.pedidoValido), 32'd0);
        @(negedge clock);
        if (code == 2'b00) begin
            check_val("pv_at_n2", 32'(bus.pedidoValido), 32'd1);
            check_val("cmd_out", 32'(bus.comando), 32'(cmd));
            check_val("addr_out", 32'(bus.endereco), 32'(addr));
            check_val("code_held", 32'(bus.codigoErro), 32'(last_code));
            check_val("no_erro_valid", 32'(erro_seen), 32'(e0));
        end else begin
            check_val("erro_at_n2", 32'(bus.erro), 32'd1);
            check_val("err_code", 32'(bus.codigoErro), 32'(code));
            check_val("pv_low_err", 32'(bus.pedidoValido), 32'd0);
            last_code = code;
            @(negedge clock);
            check_val("erro_one_cycle", 32'(bus.erro), 32'd0);
            check_val("erro_count", 32'(erro_seen), 32'(e0 + 1));
        end
    endtask

    task automatic hold_and_ack(input logic [7:0] cmd, input logic [7:0] addr, input int hold,
                                input bit noise);
        int d0;
        bit held;
        held = 1'b1;
        repeat (hold) begin
            @(negedge clock);
            if (!(bus.pedidoValido && bus.comando == cmd && bus.endereco == addr)) held = 1'b0;
        end
        check_val("hold_stable", 32'(held), 32'd1);
        if (noise) begin
            d0 = desc_seen;
            send_byte(1'b0, 8'($urandom));
            send_byte(1'b1, 8'($urandom));
            check_val("pend_discard", 32'(desc_seen), 32'(d0 + 1));
            check_val("pend_pv_kept", 32'(bus.pedidoValido), 32'd1);
            check_val("pend_cmd_kept", 32'(bus.comando), 32'(cmd));
        end
        bus.pedidoAceito = 1'b1;
        @(negedge clock);
        bus.pedidoAceito = 1'b0;
        check_val("ack_drop", 32'(bus.pedidoValido), 32'd0);
        check_val("cmd_after_ack", 32'(bus.comando), 32'(cmd));
        check_val("addr_after_ack", 32'(bus.endereco), 32'(addr));
    endtask

    task automatic ack_with_pair(input logic [7:0] cmd, input logic [7:0] addr);
        int d0;
        d0 = desc_seen;
        send_byte(1'b0, 8'($urandom));
        bus.segundoByte    = 8'($urandom);
        bus.bytesRecebidos = 1'b1;
        bus.pedidoAceito   = 1'b1;
        @(negedge clock);
        bus.bytesRecebidos = 1'b0;
        bus.pedidoAceito   = 1'b0;
        check_val("ackpair_pv", 32'(bus.pedidoValido), 32'd0);
        check_val("ackpair_desc", 32'(desc_seen), 32'(d0 + 1));
        check_val("ackpair_cmd", 32'(bus.comando), 32'(cmd));
        check_val("ackpair_addr", 32'(bus.endereco), 32'(addr));
    endtask

    task automatic do_timeout(input logic [7:0] b);
        int e0;
        int d0;
        e0 = erro_seen;
        d0 = desc_seen;
        send_byte(1'b0, b);
        repeat (Timeout - 5) @(negedge clock);
        check_val("no_early_timeout", 32'(erro_seen), 32'(e0));
        repeat (15) @(negedge clock);
        check_val("timeout_erro", 32'(erro_seen), 32'(e0 + 1));
        check_val("timeout_code", 32'(bus.codigoErro), 32'd3);
        last_code = 2'b11;
        send_byte(1'b1, 8'($urandom));
        check_val("orphan_discard", 32'(desc_seen), 32'(d0 + 1));
    endtask

    initial begin
        logic [1:0] code;
        int         e0;
        int         d0;
        n_tests            = 0;
        n_fail             = 0;
        last_code          = 2'b00;
        reset_n            = 1'b0;
        bus.bytesRecebidos = 1'b0;
        bus.primeiroByte   = 8'h00;
        bus.segundoByte    = 8'h00;
        bus.pedidoAceito   = 1'b0;
        repeat (3) @(negedge clock);
        check_cleared("reset");
        reset_n = 1'b1;
        @(negedge clock);

        run_pair(8'h01, 8'h05, 40, code);
        hold_and_ack(8'h01, 8'h05, 10, 1'b0);
        run_pair(8'h09, 8'h03, 3, code);
        run_pair(8'h02, 8'h20, 7, code);
        run_pair(8'hFF, 8'hFF, 2, code);
        do_timeout(8'h03);
        run_pair(8'h00, 8'h00, 4, code);
        hold_and_ack(8'h00, 8'h00, 2, 1'b1);
        run_pair(8'h03, 8'h10, 1, code);
        ack_with_pair(8'h03, 8'h10);

        // Asynchronous reset while waiting for the second byte, then while pending.
        e0 = erro_seen;
        d0 = desc_seen;
        send_byte(1'b0, 8'h04);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_cleared("rst_wait");
        @(negedge clock);
        reset_n   = 1'b1;
        last_code = 2'b00;
        run_pair(8'h05, 8'h1F, 6, code);
        hold_and_ack(8'h05, 8'h1F, 1, 1'b0);
        run_pair(8'h02, 8'h11, 0, code);
        #2 reset_n = 1'b0;
        #1 check_cleared("rst_pend");
        @(negedge clock);
        reset_n = 1'b1;
        check_val("rst_no_erro", 32'(erro_seen), 32'(e0));
        check_val("rst_no_desc", 32'(desc_seen), 32'(d0));
        run_pair(8'h06, 8'h1E, 9, code);
        hold_and_ack(8'h06, 8'h1E, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            logic [7:0]  c;
            logic [7:0]  a;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                do_timeout(8'($urandom));
            end else begin
                c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 36));
                run_pair(c, a, int'($urandom_range(0, 60)), code);
                if (code == 2'b00) begin
                    if (kind == 1) ack_with_pair(c, a);
                    else hold_and_ack(c, a, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
                end
            end
            repeat ($urandom_range(0, 4)) @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decodificador_comando.md
DECODIFICADOR_COMANDO -- requirements
Module: decodificador_comando

Interface
REQ-001 Parameter CICLOS_TIMEOUT, default 104180: clock cycles allowed between first and second byte (20 bit-times at 5209 clocks/bit).
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 bytesRecebidos  input  1  one-cycle pulse from the UART receiver per received byte.
REQ-005 primeiroByte  input  8  first byte of the pair (command); valid in the cycle its pulse is high.
REQ-006 segundoByte  input  8  second byte of the pair (address); valid in the cycle its pulse is high.
REQ-007 pedidoAceito  input  1  downstream acknowledge of the pending request.
REQ-008 pedidoValido  output  1  level; request pending, held until acknowledged.
REQ-009 comando  output  8  decoded command, stable while pedidoValido=1.
REQ-010 endereco  output  8  sensor address, stable while pedidoValido=1.
REQ-011 erro  output  1  one-cycle error pulse.
REQ-012 codigoErro  output  2  01 invalid command, 10 invalid address, 11 timeout; holds the last error code.
REQ-013 descartado  output  1  one-cycle pulse when a completed pair or orphan byte is dropped.

Function
REQ-014 FSM states: ESPERA, AGUARDA_SEGUNDO, VALIDA, PENDENTE, ERRO.
REQ-015 Internal 1-bit paridade toggles on every bytesRecebidos pulse in every state, mirroring the receiver's byte alternation.
REQ-016 Timeout behaviour does not reset paridade.
REQ-017 ESPERA, pulse with paridade=0 -> AGUARDA_SEGUNDO; clear timeout counter.
REQ-018 ESPERA, pulse with paridade=1 (orphan second byte) -> descartado pulse next cycle; remain in ESPERA.
REQ-019 AGUARDA_SEGUNDO, pulse -> capture primeiroByte/segundoByte into internal registers on that edge; go to VALIDA.
REQ-020 AGUARDA_SEGUNDO, no pulse: increment 18-bit timeout counter.
REQ-021 AGUARDA_SEGUNDO, counter reaches CICLOS_TIMEOUT-1 -> ERRO with code 11.
REQ-022 AGUARDA_SEGUNDO, pulse and timeout in the same cycle: the pulse wins.
REQ-023 VALIDA, command validity: valid set is 8'h00..8'h06; otherwise -> ERRO, code 01.
REQ-024 VALIDA, address validity: valid range is 8'h00..8'h1F; otherwise -> ERRO, code 10.
REQ-025 VALIDA, both invalid: code 01 takes priority.
REQ-026 VALIDA, both valid -> PENDENTE; load comando/endereco; pedidoValido=1.
REQ-027 Latency: second-byte pulse sampled at edge N -> pedidoValido high after edge N+2.
REQ-028 PENDENTE: pedidoValido, comando and endereco held constant.
REQ-029 PENDENTE: pedidoAceito sampled high -> pedidoValido low after the next edge; go to ESPERA.
REQ-030 PENDENTE: a pulse completing a pair (paridade=1) -> descartado pulse; a pulse with paridade=0 is silently absorbed.
REQ-031 PENDENTE: simultaneous ack and pair completion -> ack honoured and pair discarded.
REQ-032 pedidoAceito outside PENDENTE is ignored.
REQ-033 ERRO: erro=1 for exactly one cycle with codigoErro updated on the same edge; -> ESPERA.
REQ-034 comando/endereco keep their last values after acknowledge; only pedidoValido qualifies them.
REQ-035 Unreachable state encodings -> ESPERA on the next edge.

Reset
REQ-036 reset_n=0 immediately forces: state ESPERA, paridade 0, counter 0, all outputs 0 (comando, endereco, codigoErro = 0).
REQ-037 Reset asserted mid-operation (any state) discards the in-flight pair with no erro/descartado pulse.
REQ-038 Operation resumes on the first rising edge after reset_n deasserts.

Verification (CICLOS_TIMEOUT=100 for bench)
REQ-039 Pulses (8'h01), then 40 cycles later (8'h05) -> pedidoValido=1 two edges after the second pulse; comando=01, endereco=05; held for 10 cycles without ack; ack -> low next cycle.
REQ-040 Pair (8'h09, 8'h03) -> single erro pulse, codigoErro=01, pedidoValido stays 0; pair (8'h02, 8'h20) -> codigoErro=10.
REQ-041 Single pulse, then nothing for 100 cycles -> erro with codigoErro=11; next pulse gives descartado; following pair (8'h00, 8'h00) -> valid request.
REQ-042 While pending, full pair arrives together with ack in the completing cycle -> one descartado pulse, pedidoValido falls, original comando/endereco unchanged.
REQ-043 reset_n pulsed low while in AGUARDA_SEGUNDO and while in PENDENTE -> all outputs 0 asynchronously; next pair decodes correctly.
REQ-044 Pair (8'hFF, 8'hFF) -> codigoErro=01 (command priority).
